// File: rtl/bram_read_arbiter.sv
// bram_read_arbiter: round-robin sharing of one read-only BRAM between
// instruction fetch (port 0) and data load (port 1), one access in flight.
module bram_read_arbiter #(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 262144
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_valid,
  input  logic [ADDR_W-1:0] p0_req_addr,
  output logic              p0_req_ready,
  output logic              p0_rsp_valid,
  output logic              p0_rsp_err,
  input  logic              p1_req_valid,
  input  logic [ADDR_W-1:0] p1_req_addr,
  output logic              p1_req_ready,
  output logic              p1_rsp_valid,
  output logic              p1_rsp_err,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPT,
    ERR
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  state_t            state;
  state_t            state_nx;
  logic              last_grant;
  logic              accept;
  logic              in_range;
  logic [ADDR_W-1:0] win_addr;

  assign accept   = p0_req_ready | p1_req_ready;
  assign win_addr = p1_req_ready ? p1_req_addr : p0_req_addr;
  assign in_range = {1'b0, win_addr} < DEPTH;

  assign mem_enable = (state == READ);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // last_grant == 1 hands a tie to port 0
  always_comb begin
    state_nx     = state;
    p0_req_ready = 1'b0;
    p1_req_ready = 1'b0;
    unique case (state)
      IDLE: begin
        p0_req_ready = p0_req_valid &
                       (~p1_req_valid | last_grant);
        p1_req_ready = p1_req_valid &
                       (~p0_req_valid | ~last_grant);
        if (p0_req_ready | p1_req_ready) begin
          state_nx = in_range ? READ : ERR;
        end
      end
      READ:    state_nx = CAPT;
      CAPT:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // out-of-range requests never reach mem_address
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= 1'b1;
      mem_address  <= '0;
      rsp_data     <= '0;
      p0_rsp_valid <= 1'b0;
      p0_rsp_err   <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p1_rsp_err   <= 1'b0;
    end else begin
      p0_rsp_valid <= 1'b0;
      p0_rsp_err   <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p1_rsp_err   <= 1'b0;
      if (accept) begin
        last_grant <= p1_req_ready;
        if (in_range) begin
          mem_address <= win_addr;
        end
      end
      if (state == CAPT) begin
        rsp_data     <= mem_data_in;
        p0_rsp_valid <= ~last_grant;
        p1_rsp_valid <= last_grant;
      end
      if (state == ERR) begin
        rsp_data     <= '0;
        p0_rsp_valid <= ~last_grant;
        p0_rsp_err   <= ~last_grant;
        p1_rsp_valid <= last_grant;
        p1_rsp_err   <= last_grant;
      end
    end
  end

endmodule

// File: tb/tb_bram_read_arbiter.sv
// tb_bram_read_arbiter: directed and random traffic against a
// transaction-level model of the two-port BRAM read arbiter.
module tb_bram_read_arbiter;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_req_valid = 1'b0;
  logic [AW-1:0] p0_req_addr = '0;
  logic          p0_req_ready;
  logic          p0_rsp_valid;
  logic          p0_rsp_err;
  logic          p1_req_valid = 1'b0;
  logic [AW-1:0] p1_req_addr = '0;
  logic          p1_req_ready;
  logic          p1_rsp_valid;
  logic          p1_rsp_err;
  logic [DW-1:0] rsp_data;
  logic          mem_enable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in = '0;
  logic          busy;

  bram_read_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MEM_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .p0_req_valid(p0_req_valid),
    .p0_req_addr (p0_req_addr),
    .p0_req_ready(p0_req_ready),
    .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_err  (p0_rsp_err),
    .p1_req_valid(p1_req_valid),
    .p1_req_addr (p1_req_addr),
    .p1_req_ready(p1_req_ready),
    .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_err  (p1_rsp_err),
    .rsp_data    (rsp_data),
    .mem_enable  (mem_enable),
    .mem_address (mem_address),
    .mem_data_in (mem_data_in),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];

  always @(posedge clk) begin
    if (mem_enable) mem_data_in <= mem[mem_address];
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // requester queues; head is presented until the DUT accepts it
  logic [AW-1:0] q0[$];
  logic [AW-1:0] q1[$];
  bit            acc0 = 0;
  bit            acc1 = 0;
  bit            glitch1 = 0;
  logic [AW-1:0] gaddr = '0;

  always @(posedge clk) begin
    #1;
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
    acc0 = 0;
    acc1 = 0;
    p0_req_valid = q0.size() > 0;
    p0_req_addr  = p0_req_valid ? q0[0] : '0;
    p1_req_valid = (q1.size() > 0) || glitch1;
    p1_req_addr  = (q1.size() > 0) ? q1[0] : gaddr;
  end

  // transaction model: expected responses with their due cycle
  typedef struct {
    int          due;
    bit          port;
    bit          err;
    logic [31:0] data;
  } rsp_t;

  rsp_t          rq[$];
  int            next_free = 0;
  int            en_cyc = -1;
  bit            lg = 1;
  bit            started = 0;
  logic [31:0]   exp_data = '0;
  logic [AW-1:0] exp_addr = '0;
  int            glog_port[$];
  int            glog_cyc[$];
  int            rsp_cnt = 0;
  int            en_cnt = 0;
  logic          rst_s = 1'b0;

  always @(posedge clk) rst_s <= rst;

  always @(negedge clk) begin
    bit            idle, r0, r1, v0, v1, e0, e1, en;
    rsp_t          r;
    logic [AW-1:0] a;
    cyc++;
    if (rst_s) begin
      rq.delete();
      next_free = cyc;
      en_cyc    = -1;
      lg        = 1;
      exp_data  = '0;
      exp_addr  = '0;
      started   = 1;
    end
    if (started) begin
      idle = cyc >= next_free;
      r0 = idle && p0_req_valid && (!p1_req_valid || lg);
      r1 = idle && p1_req_valid && (!p0_req_valid || !lg);
      v0 = 0; v1 = 0; e0 = 0; e1 = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        if (rq[0].port) begin v1 = 1; e1 = rq[0].err; end
        else begin v0 = 1; e0 = rq[0].err; end
        exp_data = rq[0].data;
        void'(rq.pop_front());
      end
      en = (cyc == en_cyc);
      chk("p0_req_ready", p0_req_ready, r0);
      chk("p1_req_ready", p1_req_ready, r1);
      chk("p0_rsp_valid", p0_rsp_valid, v0);
      chk("p1_rsp_valid", p1_rsp_valid, v1);
      if (v0) chk("p0_rsp_err", p0_rsp_err, e0);
      if (v1) chk("p1_rsp_err", p1_rsp_err, e1);
      chk("rsp_data", rsp_data, exp_data);
      chk("mem_enable", mem_enable, en);
      chk("mem_address", mem_address, exp_addr);
      chk("busy", busy, !idle);
      if (mem_enable) en_cnt++;
      if (p0_rsp_valid || p1_rsp_valid) rsp_cnt++;
      acc0 = p0_req_valid && p0_req_ready;
      acc1 = p1_req_valid && p1_req_ready;
      if (!rst && (r0 || r1)) begin
        a      = r1 ? p1_req_addr : p0_req_addr;
        r.port = r1;
        r.err  = a >= DEPTH;
        r.due  = cyc + (r.err ? 2 : 3);
        r.data = r.err ? 32'h0 : mem[a];
        rq.push_back(r);
        next_free = r.due;
        lg = r1;
        if (!r.err) begin
          en_cyc   = cyc + 1;
          exp_addr = a;
        end
        glog_port.push_back(r1 ? 1 : 0);
        glog_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int lim, output bit ok, output int c);
    ok = 0;
    c  = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      step();
      if (p0_rsp_valid || p1_rsp_valid) begin
        ok = 1;
        c  = cyc;
      end
    end
    if (!ok) chk("rsp_timeout", 0, 1);
  endtask

  task automatic wait_grants(input int n, input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      step();
      ok = glog_cyc.size() >= n;
    end
    if (!ok) chk("grant_timeout", glog_cyc.size(), n);
  endtask

  task automatic drain(input int lim);
    bit done = 0;
    for (int i = 0; i < lim && !done; i++) begin
      step();
      done = q0.size() == 0 && q1.size() == 0 && rq.size() == 0 &&
             !p0_req_valid && !p1_req_valid && !busy;
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
  endtask

  initial begin
    bit ok;
    int c, n, e0, r0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hFFFF_0000 + i;
    mem[0] = 32'h1111_0000;
    mem[1] = 32'hCAFE_0001;
    mem[2] = 32'h0BAD_0002;
    mem[3] = 32'hE3A0_1005;
    mem[4] = 32'hDEAD_0004;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("reset_busy", busy, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_mem_address", mem_address, 0);
    chk("reset_mem_enable", mem_enable, 0);

    // single good read from port 0
    n = glog_cyc.size();
    q0.push_back(4'd3);
    wait_rsp(12, ok, c);
    if (ok) begin
      chk("A_latency", c - glog_cyc[n], 3);
      chk("A_p0_valid", p0_rsp_valid, 1);
      chk("A_data", rsp_data, 32'hE3A0_1005);
    end
    drain(20);

    // simultaneous requests alternate, port 0 first after reset
    do_reset();
    n = glog_cyc.size();
    q0.push_back(4'd0); q0.push_back(4'd1);
    q1.push_back(4'd2); q1.push_back(4'd3);
    wait_grants(n + 4, 30, ok);
    if (ok) begin
      for (int i = 0; i < 4; i++) chk("tie_order", glog_port[n+i], i % 2);
      for (int i = 0; i < 3; i++)
        chk("tie_spacing", glog_cyc[n+i+1] - glog_cyc[n+i], 3);
    end
    drain(30);

    // out-of-range request never touches the BRAM
    e0 = en_cnt;
    n  = glog_cyc.size();
    q1.push_back(4'd5);
    wait_rsp(12, ok, c);
    if (ok) begin
      chk("E_latency", c - glog_cyc[n], 2);
      chk("E_p1_valid", p1_rsp_valid, 1);
      chk("E_p1_err", p1_rsp_err, 1);
      chk("E_data", rsp_data, 0);
    end
    drain(20);
    chk("E_no_enable", en_cnt - e0, 0);

    // back-to-back port 0, last one at the top legal address
    e0 = en_cnt;
    n  = glog_cyc.size();
    q0.push_back(4'd0); q0.push_back(4'd1);
    q0.push_back(4'd2); q0.push_back(4'd4);
    wait_grants(n + 4, 30, ok);
    if (ok) begin
      for (int i = 0; i < 3; i++)
        chk("b2b_spacing", glog_cyc[n+i+1] - glog_cyc[n+i], 3);
    end
    drain(30);
    chk("b2b_enables", en_cnt - e0, 4);
    chk("b2b_last_data", rsp_data, 32'hDEAD_0004);

    // reset while the BRAM read is in flight
    n = glog_cyc.size();
    q0.push_back(4'd2);
    wait_grants(n + 1, 12, ok);
    @(posedge clk);
    #1;
    chk("R_in_read", mem_enable, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    r0 = rsp_cnt;
    repeat (4) step();
    chk("R_no_rsp", rsp_cnt - r0, 0);
    chk("R_busy", busy, 0);
    chk("R_data", rsp_data, 0);
    chk("R_addr", mem_address, 0);
    q0.push_back(4'd1);
    wait_rsp(12, ok, c);
    if (ok) chk("R_after_data", rsp_data, 32'hCAFE_0001);
    drain(20);

    // port 1 pulses valid only while busy: no grant
    n = glog_cyc.size();
    q0.push_back(4'd4);
    wait_grants(n + 1, 12, ok);
    gaddr   = 4'd2;
    glitch1 = 1;
    step();
    glitch1 = 0;
    drain(20);
    chk("G_no_grant", glog_cyc.size(), n + 1);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      c = int'($urandom_range(0, 3));
      if (c[0]) q0.push_back(AW'($urandom_range(0, 6)));
      if (c[1]) q1.push_back(AW'($urandom_range(0, 6)));
      repeat ($urandom_range(1, 4)) step();
    end
    drain(400);
    chk("rsp_per_grant", rsp_cnt, glog_cyc.size() - 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
